axil_bram_init_slave: RTL
=========================

// Module: axil_bram_init_slave
// PURPOSE
// AXI4-Lite responder (slave end) mapped at the 4 KB window driven by the
// block-design AXI VIP master. It exposes a small register map: a scratch
// register, a BRAM pointer, an auto-incrementing BRAM data window and a
// read-only ID. The block sits between the AXI interconnect and one port of
// the sampler's initialisation BRAM (1-cycle read latency).
// PARAMETERS
// DATA_W    32            AXI data width; fixed at 32 bits (AXI4-Lite).
// ADDR_W    32            AXI address width.
// BRAM_AW   10            BRAM word-address width; the pointer wraps at 2**BRAM_AW.
// ID_VALUE  32'h1513_0001 Constant returned by a read of the ID register.
// PORTS
// aclk         in   1         Clock. Everything is sampled on the rising edge.
// areset       in   1         Reset. Asynchronous, active-high.
// s_awaddr     in   ADDR_W    Write address.  s_awprot in 3: ignored.
// s_awvalid/s_awready  in/out 1  Write-address handshake.
// s_wdata      in   32        Write data.  s_wstrb in 4: only 4'hF writes; any other value -> SLVERR.
// s_wvalid/s_wready    in/out 1  Write-data handshake.
// s_bresp      out  2         Write response: OKAY = 2'b00, SLVERR = 2'b10.
// s_bvalid/s_bready    out/in 1  Write-response handshake.
// s_araddr     in   ADDR_W    Read address.  s_arprot in 3: ignored.
// s_arvalid/s_arready  in/out 1  Read-address handshake.
// s_rdata      out  32        Read data.  s_rresp out 2: response code.
// s_rvalid/s_rready    out/in 1  Read-data handshake.
// bram_en      out  1         BRAM port enable.
// bram_we      out  1         BRAM write enable.
// bram_addr    out  BRAM_AW   BRAM word address.
// bram_wdata   out  32        BRAM write data.
// bram_rdata   in   32        BRAM read data; valid 1 cycle after bram_en with bram_we = 0.
// BEHAVIOUR
// Register map (decode on addr[11:0]; any addr[11:4] != 0 is unmapped):
//  0x0 SCRATCH  RW, reset 0.
//  0x4 PTR      RW. Bits [BRAM_AW-1:0] are used; a read zero-extends.
//  0x8 DATA     Write: bram[PTR] <= wdata, then PTR++.
//               Read: returns bram[PTR], then PTR++.
//               PTR wraps from 2**BRAM_AW-1 to 0.
//  0xC ID       RO, returns ID_VALUE. A write gets SLVERR with no effect.
//  Unmapped     SLVERR, rdata = 0, no state change.
// Reset: all readies 0; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0;
//   bram_en = bram_we = 0; SCRATCH = PTR = 0; FSM enters IDLE.
//   Reset mid-transaction drops the transaction; no response is issued.
// FSM states: IDLE, WR_RESP, RD_WAIT, RD_RESP. One transaction is in flight at a time.
//  IDLE: AW and W may arrive in either order and at any skew; each is latched
//    on its own handshake. awready/wready = 1 while the matching channel has
//    not yet been latched.
//    Once both are latched: perform the write, go to WR_RESP, bvalid = 1 on the next cycle.
//    Else if arvalid: arready = 1 for one cycle.
//      DATA read: drive bram_en, go to RD_WAIT.
//      Any other read: load rdata, go to RD_RESP.
//  RD_WAIT: capture bram_rdata into rdata, go to RD_RESP.
//  WR_RESP / RD_RESP: hold valid and response stable until ready; then return
//    to IDLE. No new address is accepted while a response is pending.
// Priority: if a complete write and an arvalid are both present in IDLE, the
//   write goes first. arready stays 0 that cycle; the read is accepted no
//   earlier than the cycle after the B handshake.
// Latency (ready held high): write AW/W -> bvalid 1 cycle.
//   Register read AR -> rvalid 1 cycle; DATA read AR -> rvalid 2 cycles.
// PTR increment happens in the handshake cycle (write) or in the RD_WAIT cycle
//   (read), so back-to-back DATA accesses are sequential.
// STRUCTURE
// Package axil_bram_pkg holds:
//  - typedef axi_resp_t (OKAY, SLVERR);
//  - the register offsets OFF_SCRATCH / OFF_PTR / OFF_DATA / OFF_ID;
//  - typedef enum slv_state_t.
// No sub-module: the BRAM stays external and decode is inline.
// TESTING
// 1. Write 0x0 = 32'h01234567, then read 0x0 -> rdata 32'h01234567, OKAY; read 0xC -> ID_VALUE.
// 2. Write PTR = 5; write DATA 32'hAAAA0001, then 32'hAAAA0002; write PTR = 5; read DATA twice
//    -> 32'hAAAA0001 then 32'hAAAA0002; a read of PTR returns 7.
// 3. PTR = 2**BRAM_AW-1; write DATA 32'h55 -> PTR reads 0; read DATA at that address -> 32'h55.
// 4. Read 0x100, then write 0x100 with 32'hFFFF -> SLVERR on both, rdata 0; SCRATCH and PTR unchanged.
// 5. wvalid 3 cycles before awvalid, then bready held low 5 cycles -> bvalid held, bresp stable,
//    arready stays 0 throughout.
// 6. AW, W and AR asserted in the same cycle -> B completes first, then R; assert areset while
//    rvalid = 1 -> rvalid drops immediately and PTR reads 0.

Source files
------------

// File: rtl/axil_bram_pkg.sv
// rtl/axil_bram_pkg.sv - shared types and register offsets for the AXI-Lite BRAM init slave
package axil_bram_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  localparam logic [3:0] OFF_SCRATCH = 4'h0;
  localparam logic [3:0] OFF_PTR     = 4'h4;
  localparam logic [3:0] OFF_DATA    = 4'h8;
  localparam logic [3:0] OFF_ID      = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    WR_RESP,
    RD_WAIT,
    RD_RESP
  } slv_state_t;

endpackage

// File: rtl/axil_bram_init_slave.sv
// rtl/axil_bram_init_slave.sv - AXI4-Lite register slave fronting one port of the init BRAM
module axil_bram_init_slave
  import axil_bram_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 32,
  parameter int          BRAM_AW  = 10,
  parameter logic [31:0] ID_VALUE = 32'h1513_0001
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [ADDR_W-1:0]  s_awaddr,
  input  logic [2:0]         s_awprot,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [DATA_W-1:0]  s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [ADDR_W-1:0]  s_araddr,
  input  logic [2:0]         s_arprot,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [DATA_W-1:0]  s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic               bram_en,
  output logic               bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [DATA_W-1:0]  bram_wdata,
  input  logic [DATA_W-1:0]  bram_rdata
);

  function automatic logic [3:0] reg_off(input logic [ADDR_W-1:0] a);
    return {a[3:2], 2'b00};
  endfunction

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return a[11:4] == 8'h00;
  endfunction

  slv_state_t         state_q, state_d;
  logic               aw_lat_q, aw_lat_d;
  logic               w_lat_q, w_lat_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [DATA_W-1:0]  scratch_q, scratch_d;
  logic [BRAM_AW-1:0] ptr_q, ptr_d;
  logic               bvalid_q, bvalid_d;
  axi_resp_t          bresp_q, bresp_d;
  logic               rvalid_q, rvalid_d;
  axi_resp_t          rresp_q, rresp_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               idle;
  logic               aw_hs, w_hs, ar_hs, wr_go, wr_ok;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [3:0]         wr_strb;

  logic unused_prot;
  assign unused_prot = ^{s_awprot, s_arprot};

  // Channel readies are combinational, so they are masked during reset
  always_comb begin
    idle      = (state_q == IDLE) && !areset;
    s_awready = idle && !aw_lat_q;
    s_wready  = idle && !w_lat_q;
    aw_hs     = s_awvalid && s_awready;
    w_hs      = s_wvalid && s_wready;
    wr_addr   = aw_lat_q ? awaddr_q : s_awaddr;
    wr_data   = w_lat_q ? wdata_q : s_wdata;
    wr_strb   = w_lat_q ? wstrb_q : s_wstrb;
    // A write whose halves are both available this cycle beats any pending read
    wr_go     = idle && (aw_lat_q || aw_hs) && (w_lat_q || w_hs);
    s_arready = idle && !wr_go && s_arvalid;
    ar_hs     = s_arready;
    wr_ok     = is_mapped(wr_addr) && (wr_strb == 4'hF) && (reg_off(wr_addr) != OFF_ID);
  end

  always_comb begin
    state_d    = state_q;
    aw_lat_d   = aw_lat_q;
    w_lat_d    = w_lat_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    scratch_d  = scratch_q;
    ptr_d      = ptr_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = ptr_q;
    bram_wdata = wr_data;

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_lat_d = 1'b1;
          awaddr_d = s_awaddr;
        end
        if (w_hs) begin
          w_lat_d = 1'b1;
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
        end
        if (wr_go) begin
          aw_lat_d = 1'b0;
          w_lat_d  = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
          state_d  = WR_RESP;
          if (wr_ok) begin
            case (reg_off(wr_addr))
              OFF_SCRATCH: scratch_d = wr_data;
              OFF_PTR:     ptr_d = wr_data[BRAM_AW-1:0];
              OFF_DATA: begin
                bram_en = 1'b1;
                bram_we = 1'b1;
                ptr_d   = ptr_q + BRAM_AW'(1);
              end
              default: ;
            endcase
          end
        end else if (ar_hs) begin
          if (is_mapped(s_araddr) && (reg_off(s_araddr) == OFF_DATA)) begin
            bram_en = 1'b1;
            state_d = RD_WAIT;
          end else begin
            rvalid_d = 1'b1;
            state_d  = RD_RESP;
            rresp_d  = RESP_OKAY;
            if (!is_mapped(s_araddr)) begin
              rresp_d = RESP_SLVERR;
              rdata_d = '0;
            end else begin
              case (reg_off(s_araddr))
                OFF_SCRATCH: rdata_d = scratch_q;
                OFF_PTR:     rdata_d = DATA_W'(ptr_q);
                default:     rdata_d = DATA_W'(ID_VALUE);
              endcase
            end
          end
        end
      end
      RD_WAIT: begin
        rdata_d  = bram_rdata;
        rresp_d  = RESP_OKAY;
        rvalid_d = 1'b1;
        ptr_d    = ptr_q + BRAM_AW'(1);
        state_d  = RD_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_RESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      scratch_q <= '0;
      ptr_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_lat_q  <= aw_lat_d;
      w_lat_q   <= w_lat_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      scratch_q <= scratch_d;
      ptr_q     <= ptr_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rresp  = rresp_q;
  assign s_rdata  = rdata_q;

endmodule
